// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer
//   Packs a stream of PIX_W-bit pixels into LANES-wide output words. An image
//   is IMG_PIXELS pixels long; its final word may be partial, with unused lanes
//   zeroed and out_lanes giving the valid count. Pixel 0 of an image is flagged
//   with out_sof, pixel IMG_PIXELS-1 with out_last.
//
//   Optional feature macro: PACKER_IMG_COUNT_EN
//     When defined, adds the 16-bit output img_count, which counts consumed
//     words carrying out_last and wraps from 65535 to 0.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_data    in   pixel value (PIX_W bits)
//   in_valid   in   pixel present
//   in_ready   out  pixel accepted when in_valid && in_ready
//   in_abort   in   drop the image in progress (pixel in that cycle ignored)
//   out_data   out  packed word, lane k at [k*PIX_W +: PIX_W]
//   out_valid  out  word present
//   out_ready  in   word consumed when out_valid && out_ready
//   out_sof    out  word holds pixel 0 of an image
//   out_last   out  word holds the last pixel of an image
//   out_lanes  out  number of valid lanes in the word
//   img_count  out  completed-image counter (PACKER_IMG_COUNT_EN only)
module pixel_stream_packer #(
  parameter int unsigned PIX_W      = 1,
  parameter int unsigned LANES      = 8,
  parameter int unsigned IMG_PIXELS = 784
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PIX_W-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_abort,
  output logic [LANES*PIX_W-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sof,
  output logic                       out_last,
`ifdef PACKER_IMG_COUNT_EN
  output logic [15:0]                img_count,
`endif
  output logic [$clog2(LANES):0]     out_lanes
);

  localparam int unsigned LW = $clog2(LANES) + 1;
  localparam int unsigned DW = LANES * PIX_W;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e          r_state;
  logic [15:0]     r_pix_idx;
  logic [LW-1:0]   r_lane;
  logic [DW-1:0]   r_pack;

  logic            w_accept;
  logic            w_consume;
  logic            w_last_pix;
  logic            w_word_full;
  logic            w_complete;
  logic            w_word_sof;
  logic [DW-1:0]   w_pack_next;

  // A new pixel can be taken whenever the output register is free or is being
  // drained this cycle; this is what gives back-to-back words with no bubble.
  assign in_ready    = !(out_valid && !out_ready);
  assign w_accept    = in_valid && in_ready && !in_abort;
  assign w_consume   = out_valid && out_ready;
  assign w_last_pix  = (r_pix_idx == 16'(IMG_PIXELS - 1));
  assign w_word_full = (r_lane == LW'(LANES - 1));
  assign w_complete  = w_word_full || w_last_pix;
  // The word under construction started at pixel index r_pix_idx - r_lane.
  assign w_word_sof  = (r_state == StIdle) || (r_pix_idx == 16'(r_lane));

  // Insert the incoming pixel into its lane; lanes not yet written stay zero
  // because r_pack is cleared after every emitted word.
  always_comb begin
    w_pack_next = r_pack;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (r_lane == LW'(k)) begin
        w_pack_next[k*PIX_W +: PIX_W] = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_pix_idx <= '0;
      r_lane    <= '0;
      r_pack    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_last  <= 1'b0;
      out_lanes <= '0;
`ifdef PACKER_IMG_COUNT_EN
      img_count <= '0;
`endif
    end else begin
      if (w_consume) begin
        out_valid <= 1'b0;
      end
`ifdef PACKER_IMG_COUNT_EN
      if (w_consume && out_last) begin
        img_count <= img_count + 16'd1;
      end
`endif
      // Abort only clears the packing side; a word already in the output
      // register stays there until consumed.
      if (in_abort) begin
        r_state   <= StIdle;
        r_pix_idx <= '0;
        r_lane    <= '0;
        r_pack    <= '0;
      end else if (w_accept) begin
        if (w_complete) begin
          out_data  <= w_pack_next;
          out_valid <= 1'b1;
          out_sof   <= w_word_sof;
          out_last  <= w_last_pix;
          out_lanes <= r_lane + LW'(1);
          r_pack    <= '0;
          r_lane    <= '0;
        end else begin
          r_pack    <= w_pack_next;
          r_lane    <= r_lane + LW'(1);
        end
        if (w_last_pix) begin
          r_state   <= StIdle;
          r_pix_idx <= '0;
        end else begin
          r_state   <= StFill;
          r_pix_idx <= r_pix_idx + 16'd1;
        end
      end
    end
  end

endmodule
